// File: rtl/cave_ioctl_pkg.sv
// Shared types and constants for the ioctl-to-DDR ROM download path.
package cave_ioctl_pkg;

  localparam logic [7:0]  ROM_INDEX_DEFAULT = 8'd0;
  localparam int unsigned BEAT_BYTES        = 8;

  typedef struct packed {
    logic [31:0]               addr;
    logic [8*BEAT_BYTES-1:0]   data;
    logic [BEAT_BYTES-1:0]     mask;
  } beat_t;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

  // Byte address of the beat holding a given 8-byte key; 32-bit wrap is ignored.
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [23:0] key);
    return base + {5'b00000, key, 3'b000};
  endfunction

endpackage

// File: rtl/beat_fifo.sv
// Synchronous first-word-fall-through FIFO of packed write beats.
module beat_fifo
  import cave_ioctl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_sys,
  input  logic                   RESET,
  input  logic                   push,
  input  beat_t                  din,
  input  logic                   pop,
  output beat_t                  dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  beat_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push & ~do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop & ~do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ioctl_rom_bridge.sv
// Packs 16-bit hps_io download words into 64-bit masked beats and streams them to DDR.
module ioctl_rom_bridge
  import cave_ioctl_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX  = ROM_INDEX_DEFAULT,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_din,
  output logic [7:0]  mem_mask,
  input  logic        mem_wait,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] WaitLevel = CW'(FIFO_DEPTH - 2);

  state_t        state_q;
  logic          dl_q, busy_q, done_q, wait_q, overflow_q;
  logic          pk_valid_q, pk_valid_d, pk_pend_q, pk_pend_d;
  logic [23:0]   pk_key_q, pk_key_d;
  logic [63:0]   pk_data_q, pk_data_d;
  logic [7:0]    pk_mask_q, pk_mask_d;

  logic          idx_ok, start, accept_ok, wr_acc, push, mem_pop, drop;
  logic [1:0]    lane;
  logic [23:0]   key;
  beat_t         push_beat, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_addr0;

  assign unused_addr0 = ioctl_addr[0];
  assign lane   = ioctl_addr[2:1];
  assign key    = ioctl_addr[26:3];
  assign idx_ok = (ioctl_index == ROM_INDEX);
  assign start  = ioctl_download & ~dl_q & idx_ok;
  // Words are taken in LOAD, or on the very cycle a new download starts.
  assign accept_ok = (state_q == LOAD) | (((state_q == IDLE) | (state_q == DRAIN)) & start);
  assign wr_acc    = ioctl_wr & ioctl_download & idx_ok & accept_ok;

  assign push = pk_valid_q & (pk_pend_q | (wr_acc & (key != pk_key_q)) | (state_q == FLUSH));
  assign push_beat = '{addr: beat_addr(BASE_ADDR, pk_key_q), data: pk_data_q, mask: pk_mask_q};
  assign mem_pop   = ~fifo_empty & ~mem_wait;
  assign drop      = push & fifo_full & ~mem_pop;

  always_comb begin
    pk_valid_d = pk_valid_q;
    pk_pend_d  = pk_pend_q;
    pk_key_d   = pk_key_q;
    pk_data_d  = pk_data_q;
    pk_mask_d  = pk_mask_q;
    if (push) begin
      pk_valid_d = 1'b0;
      pk_pend_d  = 1'b0;
      pk_mask_d  = '0;
    end
    if (wr_acc) begin
      // The outgoing beat (if any) is already captured by push_beat, so start clean.
      if (push | ~pk_valid_q) begin
        pk_data_d = '0;
        pk_mask_d = '0;
      end
      pk_valid_d = 1'b1;
      pk_key_d   = key;
      pk_data_d[{lane, 4'b0000} +: 16] = ioctl_dout;
      pk_mask_d[{lane, 1'b0} +: 2]     = 2'b11;
      if (lane == 2'd3) pk_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wait_q     <= 1'b0;
      overflow_q <= 1'b0;
      pk_valid_q <= 1'b0;
      pk_pend_q  <= 1'b0;
      pk_key_q   <= '0;
      pk_data_q  <= '0;
      pk_mask_q  <= '0;
    end else begin
      dl_q       <= ioctl_download;
      wait_q     <= (fifo_count >= WaitLevel);
      overflow_q <= overflow_q | drop;
      pk_valid_q <= pk_valid_d;
      pk_pend_q  <= pk_pend_d;
      pk_key_q   <= pk_key_d;
      pk_data_q  <= pk_data_d;
      pk_mask_q  <= pk_mask_d;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD:  if (!ioctl_download) state_q <= FLUSH;
        FLUSH: state_q <= DRAIN;
        DRAIN: begin
          if (start) begin
            state_q <= LOAD;
          end else if (fifo_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  beat_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys(clk_sys),
    .RESET  (RESET),
    .push   (push),
    .din    (push_beat),
    .pop    (mem_pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign mem_wr     = ~fifo_empty;
  assign mem_addr   = fifo_empty ? '0 : head.addr;
  assign mem_din    = fifo_empty ? '0 : head.data;
  assign mem_mask   = fifo_empty ? '0 : head.mask;
  assign ioctl_wait = wait_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_rom_bridge.sv
// Directed and randomized checks of ioctl_rom_bridge against a beat-grouping reference model.
module tb_ioctl_rom_bridge;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } tb_beat_t;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        ioctl_download, ioctl_wr, ioctl_wait, mem_wr, mem_wait, busy, done, overflow;
  logic [7:0]  ioctl_index, mem_mask;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [31:0] mem_addr;
  logic [63:0] mem_din;

  always #5 clk_sys = ~clk_sys;

  ioctl_rom_bridge #(
    .ROM_INDEX (8'd0),
    .BASE_ADDR (32'h3000_0000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_sys       (clk_sys),
    .RESET         (RESET),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_mask      (mem_mask),
    .mem_wait      (mem_wait),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  int       n_assert = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  int       done_cnt = 0;
  int       acc_cyc  = 0;
  int       done_cyc = 0;
  bit       rand_mw  = 1'b0;
  tb_beat_t got[$];
  tb_beat_t exp_q[$];

  // Reference packer: one open beat, closed on key change, lane 3, or end of download.
  bit          cur_v = 1'b0;
  logic [23:0] cur_key;
  logic [63:0] cur_data;
  logic [7:0]  cur_mask;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (RESET === 1'b0) begin
      if (mem_wr && !mem_wait) begin
        got.push_back('{mem_addr, mem_din, mem_mask});
        acc_cyc <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (rand_mw) mem_wait = 1'($urandom_range(0, 1));
  endtask

  task automatic model_close();
    exp_q.push_back('{32'h3000_0000 + 32'(cur_key) * 8, cur_data, cur_mask});
    cur_v = 1'b0;
  endtask

  task automatic model_word(input logic [26:0] a, input logic [15:0] d);
    int lane;
    lane = int'(a[2:1]);
    if (cur_v && a[26:3] != cur_key) model_close();
    if (!cur_v) begin
      cur_v    = 1'b1;
      cur_key  = a[26:3];
      cur_data = '0;
      cur_mask = '0;
    end
    cur_data[lane*16 +: 16] = d;
    cur_mask[lane*2 +: 2]   = 2'b11;
    if (lane == 3) model_close();
  endtask

  task automatic write_word(input logic [26:0] a, input logic [15:0] d, input bit honor);
    int st;
    st = 0;
    while (honor && ioctl_wait && st < 300) begin
      tick();
      st++;
    end
    if (st == 300) chk("wait_bound", 64'(ioctl_wait), 64'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    if (ioctl_index == 8'd0) model_word(a, d);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    if (ioctl_index == 8'd0 && cur_v) model_close();
    tick();
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_cnt == prev && t < 500) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk("done_once", 64'(done_cnt), 64'(prev + 1));
  endtask

  function automatic logic [63:0] bytemask(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk({tag, "_addr"}, 64'(got[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_mask"}, 64'(got[i].mask), 64'(exp_q[i].mask));
      chk({tag, "_data"}, got[i].data & bytemask(exp_q[i].mask),
          exp_q[i].data & bytemask(exp_q[i].mask));
    end
    got.delete();
    exp_q.delete();
  endtask

  int          prev;
  int          nw;
  logic [7:0]  idx;
  logic [23:0] kb;
  logic [26:0] ra;

  initial begin
    RESET = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    mem_wait = 1'b0;
    repeat (3) tick();
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_din", mem_din, 64'd0);
    chk("rst_mem_mask", 64'(mem_mask), 64'd0);
    chk("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    RESET = 1'b0;
    tick();

    // Full beat, latency and done timing
    prev = done_cnt;
    start_dl(8'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    write_word(27'h0, 16'h1111, 1'b1);
    write_word(27'h2, 16'h2222, 1'b1);
    write_word(27'h4, 16'h3333, 1'b1);
    write_word(27'h6, 16'h4444, 1'b1);
    chk("t1_lat_early", 64'(mem_wr), 64'd0);
    tick();
    chk("t1_lat_mem_wr", 64'(mem_wr), 64'd1);
    end_dl();
    wait_done(prev);
    chk("t1_done_gap", 64'(done_cyc - acc_cyc >= 2), 64'd1);
    chk("t1_addr_const", 64'(got[0].addr), 64'h3000_0000);
    chk("t1_data_const", got[0].data, 64'h4444_3333_2222_1111);
    chk("t1_mask_const", 64'(got[0].mask), 64'hFF);
    chk("t1_busy_after", 64'(busy), 64'd0);
    check_beats("t1");

    // Partial beat flushed at end of download
    prev = done_cnt;
    start_dl(8'd0);
    write_word(27'h10, 16'hAAAA, 1'b1);
    write_word(27'h12, 16'hBBBB, 1'b1);
    end_dl();
    wait_done(prev);
    chk("t2_mask_const", 64'(got[0].mask), 64'h0F);
    check_beats("t2");

    // Key change pushes the old beat
    prev = done_cnt;
    start_dl(8'd0);
    write_word(27'h0, 16'h0123, 1'b1);
    write_word(27'h20, 16'h4567, 1'b1);
    end_dl();
    wait_done(prev);
    check_beats("t3");

    // Backpressure threshold and ordered release
    prev = done_cnt;
    mem_wait = 1'b1;
    start_dl(8'd0);
    for (int b = 0; b < 8; b++) begin
      if (b == 6) begin
        chk("t4_held", 64'(got.size()), 64'd0);
        mem_wait = 1'b0;
        repeat (4) tick();
        chk("t4_wait_fall", 64'(ioctl_wait), 64'd0);
      end
      for (int w = 0; w < 4; w++)
        write_word(27'(b * 8 + w * 2), 16'(b * 16 + w), 1'b1);
      repeat (3) tick();
      if (b < 6) chk("t4_wait_level", 64'(ioctl_wait), 64'(b + 1 >= 6));
    end
    end_dl();
    wait_done(prev);
    chk("t4_overflow", 64'(overflow), 64'd0);
    check_beats("t4");

    // HPS ignores ioctl_wait: ninth beat is dropped
    prev = done_cnt;
    mem_wait = 1'b1;
    start_dl(8'd0);
    for (int b = 0; b < 9; b++) begin
      for (int w = 0; w < 4; w++)
        write_word(27'(27'h100 + b * 8 + w * 2), 16'($urandom), 1'b0);
      repeat (3) tick();
      chk("t5_overflow_step", 64'(overflow), 64'(b + 1 > 8));
    end
    end_dl();
    mem_wait = 1'b0;
    wait_done(prev);
    void'(exp_q.pop_back());
    check_beats("t5");
    chk("t5_sticky", 64'(overflow), 64'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    chk("t5_cleared", 64'(overflow), 64'd0);

    // Reset in DRAIN with queued beats, then a foreign-index download
    mem_wait = 1'b1;
    start_dl(8'd0);
    for (int w = 0; w < 12; w++) write_word(27'(27'h200 + w * 2), 16'(w), 1'b0);
    end_dl();
    repeat (3) tick();
    chk("t6_busy_drain", 64'(busy), 64'd1);
    chk("t6_mem_wr_drain", 64'(mem_wr), 64'd1);
    prev = done_cnt;
    #2 RESET = 1'b1;
    #1;
    chk("t6_rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_wait", 64'(ioctl_wait), 64'd0);
    tick();
    tick();
    RESET = 1'b0;
    mem_wait = 1'b0;
    cur_v = 1'b0;
    exp_q.delete();
    repeat (20) tick();
    chk("t6_no_done", 64'(done_cnt), 64'(prev));
    start_dl(8'd1);
    chk("t6_idx1_busy", 64'(busy), 64'd0);
    for (int w = 0; w < 4; w++) write_word(27'(w * 2), 16'hDEAD, 1'b1);
    end_dl();
    repeat (20) tick();
    chk("t6_idx1_idle", 64'(busy), 64'd0);
    chk("t6_idx1_done", 64'(done_cnt), 64'(prev));
    check_beats("t6");

    // Randomized downloads against the reference model with random mem_wait
    rand_mw = 1'b1;
    for (int d = 0; d < 10; d++) begin
      idx  = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
      prev = done_cnt;
      kb   = 24'($urandom_range(0, 32'hFFFF00));
      nw   = $urandom_range(1, 24);
      start_dl(idx);
      for (int w = 0; w < nw; w++) begin
        ra = {kb + 24'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
        write_word(ra, 16'($urandom), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      end_dl();
      if (idx == 8'd0) begin
        wait_done(prev);
      end else begin
        repeat (10) tick();
        chk("rnd_idx1_busy", 64'(busy), 64'd0);
        chk("rnd_idx1_done", 64'(done_cnt), 64'(prev));
      end
      check_beats("rnd");
    end
    rand_mw = 1'b0;
    mem_wait = 1'b0;
    chk("rnd_overflow", 64'(overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
